stack_ctrl: RTL
===============

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter DATA_W, default 135, SHALL set the data word width.
REQ-002 Parameter DEPTH, default 128, SHALL set the stack capacity in entries.
REQ-003 clk  in  1  SHALL be the single clock; all logic SHALL sample on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid  in  1  SHALL mean a request is offered.
REQ-006 req_ready  out  1  SHALL mean the controller accepts the request this cycle.
REQ-007 req_op  in  2  SHALL encode the operation: 00 push, 01 pop, 10 peek, 11 reserved.
REQ-008 req_data  in  DATA_W  SHALL carry the push payload.
REQ-009 rsp_valid  out  1  SHALL mean a response is presented.
REQ-010 rsp_ready  in  1  SHALL mean the consumer takes the response.
REQ-011 rsp_data  out  DATA_W  SHALL carry the popped or peeked word, or zero.
REQ-012 rsp_err  out  1  SHALL flag a rejected request.
REQ-013 stk_in  out  DATA_W, stk_push/stk_pop/stk_top  out  1 each, stk_out  in  DATA_W: these SHALL form the stack-side port.
REQ-014 depth  out  $clog2(DEPTH)+1  SHALL give the current occupancy; full and empty  out  1 each SHALL flag depth==DEPTH and depth==0.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, CAPTURE and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE; a handshake occurs when req_valid&req_ready is 1 at a rising edge.
REQ-017 An accepted valid request (push when not full, pop/peek when not empty) SHALL go IDLE->ISSUE.
REQ-018 In ISSUE, exactly one of stk_push/stk_pop/stk_top SHALL be 1 for exactly one cycle, with stk_in=req_data latched at acceptance.
REQ-019 A push SHALL go ISSUE->RESP and increment depth at the end of ISSUE.
REQ-020 A pop SHALL decrement depth at the end of ISSUE; pop and peek SHALL go ISSUE->CAPTURE.
REQ-021 In CAPTURE, stk_out SHALL be registered into rsp_data and the FSM SHALL go to RESP.
REQ-022 Latency from acceptance at edge N: push rsp_valid in cycle N+2; pop/peek rsp_valid in cycle N+3.
REQ-023 Push on full, pop/peek on empty, or op 11 SHALL go IDLE->RESP with no stack strobe, rsp_err=1, rsp_data=0 and depth unchanged (rsp_valid in cycle N+1).
REQ-024 A successful push SHALL respond with rsp_err=0 and rsp_data=0.
REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL be held stable until rsp_valid&rsp_ready; the FSM SHALL then go to IDLE.
REQ-026 At most one request SHALL be outstanding; back-to-back throughput SHALL be one request per (latency+1) cycles.
REQ-027 depth SHALL never exceed DEPTH nor wrap below 0.
REQ-028 All stack strobes SHALL be 0 outside ISSUE.

Reset
REQ-029 On rst, the FSM SHALL enter IDLE and depth SHALL be 0 (so empty=1, full=0).
REQ-030 On rst, rsp_valid, rsp_err and all stk_* strobes SHALL be 0, and rsp_data and stk_in SHALL be 0.
REQ-031 rst asserted mid-operation (any state) SHALL abort the request with no response; the same rst SHALL also reset the attached stack.
REQ-032 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-033 Package stack_pkg SHALL hold DATA_W, DEPTH, the op encoding enum and the FSM state enum.
REQ-034 The occupancy counter SHALL be one sub-module, stack_depth_cnt (inc, dec, depth, full, empty); all other logic SHALL stay inline.

Verification
REQ-035 After reset, push 135'h1 then pop -> stk_push in the cycle after acceptance; pop rsp_data=135'h1, rsp_err=0, rsp_valid at N+3; depth 0->1->0.
REQ-036 Pop with depth 0 -> rsp_valid at N+1, rsp_err=1, rsp_data=0, no stk_pop pulse, depth stays 0.
REQ-037 128 pushes of values 0..127, then a 129th push -> full=1, the 129th returns rsp_err=1 with no stk_push; then 128 pops -> 127 down to 0.
REQ-038 Push 135'hA5, peek twice -> both responses give 135'hA5; depth stays 1; stk_top pulses once per peek.
REQ-039 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0 throughout.
REQ-040 rst asserted in CAPTURE with depth 3 -> next cycle IDLE, depth 0, rsp_valid 0, strobes 0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller.
//   DATA_W / DEPTH : default word width and stack capacity
//   op_e           : request operation encoding carried on req_op
//   state_e        : controller FSM states
package stack_pkg;

    localparam int DATA_W = 135;
    localparam int DEPTH  = 128;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_PEEK = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_RESP    = 2'b11
    } state_e;

endpackage

// File: rtl/stack_depth_cnt.sv
// Occupancy counter for the stack controller.
//   clk, rst : clock and synchronous active-high reset
//   inc      : one entry was pushed this cycle
//   dec      : one entry was popped this cycle
//   depth    : current occupancy, 0..DEPTH
//   full     : depth == DEPTH
//   empty    : depth == 0
module stack_depth_cnt #(
    parameter int DEPTH = stack_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc,
    input  logic                   dec,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   full,
    output logic                   empty
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_MAX = CW'(DEPTH);

    logic [CW-1:0] depth_reg;
    logic [CW-1:0] depth_next;

    // Saturate at both ends so a stray strobe can never wrap the count.
    always_comb begin
        depth_next = depth_reg;
        if (inc && !dec && depth_reg != DEPTH_MAX) begin
            depth_next = depth_reg + CW'(1);
        end else if (dec && !inc && depth_reg != '0) begin
            depth_next = depth_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_reg <= '0;
        end else begin
            depth_reg <= depth_next;
        end
    end

    assign depth = depth_reg;
    assign full  = (depth_reg == DEPTH_MAX);
    assign empty = (depth_reg == '0);

endmodule

// File: rtl/stack_ctrl.sv
// Request/response front end for an external stack.
//   clk, rst                      : clock and synchronous active-high reset
//   req_valid/req_ready/req_op/req_data : request channel (00 push, 01 pop, 10 peek, 11 reserved)
//   rsp_valid/rsp_ready/rsp_data/rsp_err : response channel, held until taken
//   stk_in/stk_push/stk_pop/stk_top/stk_out : stack-side port; strobes are one-cycle
//                                   pulses in ISSUE, stk_out is sampled in CAPTURE
//   depth/full/empty              : occupancy tracking
// One request is in flight at a time: IDLE -> ISSUE -> (CAPTURE) -> RESP -> IDLE,
// rejected requests go straight from IDLE to RESP.
module stack_ctrl #(
    parameter int DATA_W = stack_pkg::DATA_W,
    parameter int DEPTH  = stack_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [DATA_W-1:0]      req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic [DATA_W-1:0]      stk_in,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic                   stk_top,
    input  logic [DATA_W-1:0]      stk_out,
    output logic [$clog2(DEPTH):0] depth,
    output logic                   full,
    output logic                   empty
);

    import stack_pkg::*;

    state_e            state_reg;
    state_e            state_next;
    op_e               op_reg;
    logic [DATA_W-1:0] stk_in_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_err_reg;

    logic accept;
    logic req_ok;
    logic cnt_inc;
    logic cnt_dec;

    assign accept = req_valid && (state_reg == ST_IDLE);

    // A request is serviceable only if the stack can honour it right now.
    always_comb begin
        req_ok = 1'b0;
        case (op_e'(req_op))
            OP_PUSH: req_ok = !full;
            OP_POP:  req_ok = !empty;
            OP_PEEK: req_ok = !empty;
            default: req_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = req_ok ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                state_next = (op_reg == OP_PUSH) ? ST_RESP : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            op_reg       <= OP_PUSH;
            stk_in_reg   <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg       <= op_e'(req_op);
                stk_in_reg   <= req_data;
                // Pushes and rejects answer with zero data; pop/peek overwrite in CAPTURE.
                rsp_data_reg <= '0;
                rsp_err_reg  <= !req_ok;
            end
            if (state_reg == ST_CAPTURE) begin
                rsp_data_reg <= stk_out;
            end
        end
    end

    // Strobes are decoded from the state so they can only ever appear in ISSUE.
    assign stk_push = (state_reg == ST_ISSUE) && (op_reg == OP_PUSH);
    assign stk_pop  = (state_reg == ST_ISSUE) && (op_reg == OP_POP);
    assign stk_top  = (state_reg == ST_ISSUE) && (op_reg == OP_PEEK);

    assign cnt_inc = stk_push;
    assign cnt_dec = stk_pop;

    stack_depth_cnt #(
        .DEPTH (DEPTH)
    ) u_depth_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .dec   (cnt_dec),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    assign req_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;
    assign stk_in    = stk_in_reg;

endmodule
